// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths, FIFO defaults and command byte codes
package uart_pkg;

  localparam int UART_DW         = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AF    = 12;

  // Command bytes recognised by the ram_rw parser
  typedef enum logic [7:0] {
    CPU_RST = 8'h2a,
    CPU_RUN = 8'h2b,
    ADDR_WR = 8'h2c,
    LEN_WR  = 8'h2d,
    DATA_WR = 8'h2e,
    DATA_RD = 8'h2f
  } uart_cmd_e;

  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DW register array, one write port, async read port
module fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT byte buffer between uart_rx and the ram_rw parser
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DW       = UART_DW,
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int AF_LEVEL = UART_FIFO_AF,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = fifo_lvl_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_vld_i,
  output logic          in_rdy_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_vld_o,
  input  logic          out_rdy_i,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic          overflow_o,
  input  logic          ovf_clr_i
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_af;
  logic          r_ovf;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [LW-1:0] w_level_nxt;
  logic [DW-1:0] w_rdata;

  // Flush wins over both sides; a byte seen on a flush cycle vanishes silently
  always_comb begin
    w_pop  = !r_empty && out_rdy_i && !flush_i;
    w_push = in_vld_i && !flush_i && (!r_full || w_pop);
    w_drop = in_vld_i && !flush_i && r_full && !w_pop;
  end

  always_comb begin
    w_level_nxt = r_level;
    if (flush_i) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + ONE_LVL;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - ONE_LVL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Flags are registered from the next level so they track r_level exactly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == FULL_LVL);
      r_af    <= (w_level_nxt >= AF_LVL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (r_wr_ptr),
    .wdata_i (in_data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_rdata)
  );

  // Memory is not reset, so the head is masked to zero while nothing is valid
  assign out_data_o    = r_empty ? '0 : w_rdata;
  assign out_vld_o     = !r_empty;
  assign in_rdy_o      = 1'b1;
  assign level_o       = r_level;
  assign empty_o       = r_empty;
  assign full_o        = r_full;
  assign almost_full_o = r_af;
  assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench with queue reference model
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [7:0] in_data_i = '0;
  logic       in_vld_i = 1'b0;
  logic       in_rdy_o;
  logic [7:0] out_data_o;
  logic       out_vld_o;
  logic       out_rdy_i = 1'b0;
  logic [4:0] level_o;
  logic       empty_o;
  logic       full_o;
  logic       almost_full_o;
  logic       overflow_o;
  logic       ovf_clr_i = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .in_data_i     (in_data_i),
    .in_vld_i      (in_vld_i),
    .in_rdy_o      (in_rdy_o),
    .out_data_o    (out_data_o),
    .out_vld_o     (out_vld_o),
    .out_rdy_i     (out_rdy_i),
    .level_o       (level_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o),
    .ovf_clr_i     (ovf_clr_i)
  );

  int        n_checks = 0;
  int        n_errors = 0;
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_after_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = m_q.size();
    chk("level", 32'(level_o), 32'(lvl));
    chk("empty", 32'(empty_o), 32'(lvl == 0));
    chk("full", 32'(full_o), 32'(lvl == DEPTH));
    chk("almost_full", 32'(almost_full_o), 32'(lvl >= AF));
    chk("out_vld", 32'(out_vld_o), 32'(lvl != 0));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("in_rdy", 32'(in_rdy_o), 32'd1);
    if (lvl != 0) chk("head_data", 32'(out_data_o), 32'(m_q[0]));
    else if (m_after_rst) chk("rst_data", 32'(out_data_o), 32'd0);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, check after the edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic r,
                       input logic f, input logic c, input logic rs);
    logic is_full, do_pop, do_push, do_drop;
    in_vld_i  = v;
    in_data_i = d;
    out_rdy_i = r;
    flush_i   = f;
    ovf_clr_i = c;
    rst_i     = rs;
    is_full = (m_q.size() == DEPTH);
    do_pop  = (m_q.size() != 0) && r && !f;
    do_push = v && !f && (!is_full || do_pop);
    do_drop = v && !f && is_full && !do_pop;
    if (do_pop && !rs) chk("pop_data", 32'(out_data_o), 32'(m_q[0]));
    m_after_rst = rs;
    if (rs) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (f) m_q.delete();
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(d);
      if (do_drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    cycle(1'b1, 8'h2a, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h2c, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    drain();

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'haa, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      logic r_bias;
      r_bias = ((i / 200) % 2) == 0;
      cycle(($urandom_range(0, 9) < 7),
            8'($urandom),
            r_bias ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 127) == 0),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 499) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer between uart_rx (upstream) and the ram_rw command parser (downstream).
- Absorbs received bytes while ram_rw is busy with RAM writes or UART replies, so back-to-back DATA_WR bytes are never lost.
- Upstream UART cannot stall, so the FIFO always accepts input. A byte that arrives while the FIFO is full is dropped and flagged.
- Output side uses the codebase data/vld/rdy handshake with first-word-fall-through semantics.

Parameters:
- DW, 8, data width in bits.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AF_LEVEL, 12, level at or above which almost_full_o asserts; range 1..DEPTH.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous clear of contents; the overflow flag is kept.
- in_data_i  in  DW  byte from uart_rx_data_o.
- in_vld_i  in  1  in_data_i valid (uart_rx_data_vld_o).
- in_rdy_o  out  1  constant 1; drives uart_rx_data_rdy_i.
- out_data_o  out  DW  head entry.
- out_vld_o  out  1  head entry valid.
- out_rdy_i  in  1  consumer accepts the head entry.
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty_o  out  1  level_o == 0.
- full_o  out  1  level_o == DEPTH.
- almost_full_o  out  1  level_o >= AF_LEVEL.
- overflow_o  out  1  sticky; at least one byte dropped.
- ovf_clr_i  in  1  clears overflow_o.

Behaviour:
- Reset values (rst_i high at a clock edge): wr_ptr=0, rd_ptr=0, level_o=0, out_vld_o=0, out_data_o=0, empty_o=1, full_o=0, almost_full_o=0, overflow_o=0. Memory contents are not reset.
- Push: occurs when in_vld_i=1 and (!full_o or pop in the same cycle). Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Each cycle in_vld_i=1 is one byte. The upstream vld pulse lasts one cycle per byte.
- Pop: occurs when out_vld_o=1 and out_rdy_i=1. Increments rd_ptr modulo DEPTH.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. level_o is a separate counter.
- level_o update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push and pop together, or on neither.
- FWFT output:
  - out_data_o = mem[rd_ptr] and out_vld_o = !empty.
  - Both come from registered state, with no combinational path from in_* to out_*.
  - Latency: a byte pushed into an empty FIFO at edge N appears on out_data_o/out_vld_o after edge N+1 at the latest. Use 1-cycle latency, with registered level/empty.
- out_data_o holds stable while out_vld_o=1 and out_rdy_i=0.
- Full with push and pop in the same cycle: both succeed, no drop, level stays DEPTH.
- Empty with in_vld_i and out_rdy_i together: push only, no pop (out_vld_o=0).
- Drop: in_vld_i=1 with full_o=1 and no pop.
  - The byte is discarded and overflow_o is set at that edge.
  - Pointers and level are unchanged.
- overflow_o priority: rst_i > set-on-drop > ovf_clr_i. A drop in the same cycle as ovf_clr_i leaves the flag set.
- flush_i:
  - Next cycle: pointers=0, level=0, out_vld_o=0.
  - Overrides push and pop in the same cycle; an incoming byte on that cycle is discarded without setting overflow.
- Reset asserted mid-stream: all queued bytes are lost and the outputs return to their reset values at that edge.

Decomposition:
- Shared package uart_pkg:
  - UART_DW = 8.
  - Default FIFO depth constant.
  - Command byte enum already used by ram_rw (CPU_RST 8'h2a … DATA_RD 8'h2f), so benches and parser share one definition.
- One sub-module, fifo_mem:
  - DEPTH x DW simple dual-port register array.
  - Write port: we, waddr, wdata.
  - Asynchronous read port: raddr -> rdata.
- uart_rx_fifo holds pointers, level counter, flags and handshake logic.

Test Plan:
1. Reset then idle → level_o=0, empty_o=1, out_vld_o=0, overflow_o=0, in_rdy_o=1.
2. Push 8'h2a, 8'h2c, 8'h00 with out_rdy_i=0, then raise out_rdy_i:
   - level reaches 3;
   - outputs pop in order 2a, 2c, 00;
   - out_data_o stays stable while stalled;
   - empty_o=1 at the end.
3. Push DEPTH=16 bytes 8'h00..8'h0f → full_o=1, almost_full_o asserted at level 12. Push 8'hff → dropped, overflow_o=1, level 16. Drain → 00..0f, no ff.
4. Full FIFO, push 8'h55 while popping → no drop, level stays 16, 8'h55 emerges last. Pulse ovf_clr_i → overflow_o=0.
5. Push and pop every cycle for 40 cycles (pointer wrap) with incrementing data → output sequence identical to input, level ≤ 1.
6. Level 5, assert flush_i together with a push of 8'haa → level 0, out_vld_o=0, overflow_o unchanged. Assert rst_i mid-stream → all outputs at reset values.
